// File: rtl/histogram_bin_ctrl.sv
// Histogram bin sequencer: bin clear, pipelined read-modify-write accumulation
// with same-bin forwarding, and host bin reads against an external read-first SDP RAM.
module histogram_bin_ctrl #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             cmd_start,
  input  logic             cmd_clear,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pix_cnt,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [PIX_W-1:0] s_tdata,
  input  logic             s_tlast,
  input  logic             hst_rd,
  input  logic [PIX_W-1:0] hst_addr,
  output logic             hst_rvalid,
  output logic [CNT_W-1:0] hst_rdata,
  output logic [PIX_W-1:0] ram_raddr,
  input  logic [CNT_W-1:0] ram_rdata,
  output logic             ram_we,
  output logic [PIX_W-1:0] ram_waddr,
  output logic [CNT_W-1:0] ram_wdata
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) sat_inc = v;
    else                    sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t             state_r, state_s;
  logic [PIX_W-1:0]   k_r, a1_r, waddr_q_r;
  logic [CNT_W-1:0]   pix_cnt_r, wdata_q_r, hst_hold_r;
  logic               v1_r, we_q_r, busy_r, done_r, tready_r, hst_rvalid_r;
  logic               accept_s, cmd_take_s, host_ok_s, fwd_s, ram_we_s;
  logic [PIX_W-1:0]   ram_raddr_s, ram_waddr_s;
  logic [CNT_W-1:0]   operand_s, ram_wdata_s;

  assign accept_s = s_tvalid && tready_r;

  // Next-state logic; a clear command takes priority over a simultaneous start
  always_comb begin
    state_s    = state_r;
    cmd_take_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (cmd_clear) begin
          state_s    = ST_CLEAR;
          cmd_take_s = 1'b1;
        end else if (cmd_start) begin
          state_s    = ST_RUN;
          cmd_take_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_CLEAR: begin
        if (k_r == {PIX_W{1'b1}}) state_s = ST_IDLE;
        else                      state_s = ST_CLEAR;
      end
      ST_RUN: begin
        if (accept_s && s_tlast) state_s = ST_DRAIN;
        else                     state_s = ST_RUN;
      end
      ST_DRAIN: state_s = ST_DONE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // RAM port muxing; the read-first RAM returns stale data when the bin was written last cycle
  always_comb begin
    host_ok_s   = hst_rd && ((state_r == ST_IDLE) || (state_r == ST_DONE)) && !cmd_take_s;
    fwd_s       = we_q_r && (waddr_q_r == a1_r);
    operand_s   = fwd_s ? wdata_q_r : ram_rdata;
    ram_raddr_s = {PIX_W{1'b0}};
    ram_we_s    = 1'b0;
    ram_waddr_s = {PIX_W{1'b0}};
    ram_wdata_s = {CNT_W{1'b0}};
    if (accept_s) begin
      ram_raddr_s = s_tdata;
    end else if (host_ok_s) begin
      ram_raddr_s = hst_addr;
    end else begin
      ram_raddr_s = {PIX_W{1'b0}};
    end
    if (state_r == ST_CLEAR) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = k_r;
      ram_wdata_s = {CNT_W{1'b0}};
    end else if (v1_r) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = a1_r;
      ram_wdata_s = sat_inc(operand_s);
    end else begin
      ram_we_s    = 1'b0;
    end
  end

  // State, status flags, counters and pipeline registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r      <= ST_IDLE;
      k_r          <= {PIX_W{1'b0}};
      pix_cnt_r    <= {CNT_W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      tready_r     <= 1'b0;
      v1_r         <= 1'b0;
      a1_r         <= {PIX_W{1'b0}};
      we_q_r       <= 1'b0;
      waddr_q_r    <= {PIX_W{1'b0}};
      wdata_q_r    <= {CNT_W{1'b0}};
      hst_rvalid_r <= 1'b0;
      hst_hold_r   <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_s;
      busy_r   <= (state_s == ST_CLEAR) || (state_s == ST_RUN) || (state_s == ST_DRAIN);
      done_r   <= (state_s == ST_DONE);
      tready_r <= (state_s == ST_RUN);
      if (state_r == ST_CLEAR) k_r <= k_r + {{(PIX_W-1){1'b0}}, 1'b1};
      else                     k_r <= {PIX_W{1'b0}};
      if (cmd_take_s && (state_s == ST_RUN)) pix_cnt_r <= {CNT_W{1'b0}};
      else if (accept_s)                     pix_cnt_r <= pix_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else                                   pix_cnt_r <= pix_cnt_r;
      v1_r      <= accept_s;
      a1_r      <= accept_s ? s_tdata : a1_r;
      we_q_r    <= ram_we_s;
      waddr_q_r <= ram_waddr_s;
      wdata_q_r <= ram_wdata_s;
      hst_rvalid_r <= host_ok_s;
      if (hst_rvalid_r) hst_hold_r <= ram_rdata;
      else              hst_hold_r <= hst_hold_r;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign s_tready   = tready_r;
  assign pix_cnt    = pix_cnt_r;
  assign hst_rvalid = hst_rvalid_r;
  assign hst_rdata  = hst_rvalid_r ? ram_rdata : hst_hold_r;
  assign ram_raddr  = ram_raddr_s;
  assign ram_we     = ram_we_s;
  assign ram_waddr  = ram_waddr_s;
  assign ram_wdata  = ram_wdata_s;

endmodule

// File: tb/tb_histogram_bin_ctrl.sv
// Self-checking bench for histogram_bin_ctrl with a read-first RAM model and a
// per-bin histogram reference model.
module tb_histogram_bin_ctrl;
  localparam int PIX_W = 8;
  localparam int CNT_W = 32;
  localparam int NBINS = 256;

  logic             ACLK = 1'b0;
  logic             ARESETN;
  logic             cmd_start, cmd_clear, busy, done;
  logic [CNT_W-1:0] pix_cnt;
  logic             s_tvalid, s_tready, s_tlast;
  logic [PIX_W-1:0] s_tdata;
  logic             hst_rd, hst_rvalid;
  logic [PIX_W-1:0] hst_addr;
  logic [CNT_W-1:0] hst_rdata;
  logic [PIX_W-1:0] ram_raddr, ram_waddr;
  logic [CNT_W-1:0] ram_rdata, ram_wdata;
  logic             ram_we;
  logic             pre_en;
  logic [PIX_W-1:0] pre_addr;
  logic [CNT_W-1:0] pre_data;

  logic [CNT_W-1:0] mem [NBINS];
  logic [CNT_W-1:0] model_bins [NBINS];
  int checks = 0;
  int failures = 0;
  int npix = 0;

  typedef struct {
    logic [PIX_W-1:0] addr;
    logic [CNT_W-1:0] cnt;
  } rd_vec_t;
  rd_vec_t rd_tab [6];

  always #5 ACLK = ~ACLK;

  histogram_bin_ctrl #(.PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .cmd_start(cmd_start), .cmd_clear(cmd_clear),
    .busy(busy), .done(done), .pix_cnt(pix_cnt),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .hst_rd(hst_rd), .hst_addr(hst_addr), .hst_rvalid(hst_rvalid), .hst_rdata(hst_rdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_we(ram_we),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata)
  );

  // Read-first synchronous RAM with a bench-side preload port
  always @(posedge ACLK) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  function automatic logic [CNT_W-1:0] sat_add1(input logic [CNT_W-1:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  task automatic check(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge ACLK);
  endtask

  task automatic read_check(input string name, input logic [PIX_W-1:0] a, input logic [CNT_W-1:0] req);
    hst_rd = 1'b1;
    hst_addr = a;
    tick();
    hst_rd = 1'b0;
    check({name, "_vld"}, {31'd0, hst_rvalid}, 32'd1);
    check(name, hst_rdata, req);
  endtask

  task automatic beat(input logic v, input logic [PIX_W-1:0] d, input logic l);
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    if (v && s_tready) begin
      model_bins[d] = sat_add1(model_bins[d]);
      npix++;
    end
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic start_run();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    npix = 0;
    check("run_tready", {31'd0, s_tready}, 32'd1);
    check("run_pixcnt_zero", pix_cnt, 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("done_reached", {31'd0, done}, 32'd1);
    check("pix_cnt", pix_cnt, npix);
  endtask

  // Called one cycle after the clear command was issued: k=0 is on the bus now
  task automatic clear_body();
    int errs = 0;
    for (int i = 0; i < NBINS; i++) begin
      if (!(busy && ram_we && (ram_waddr == i[PIX_W-1:0]) && (ram_wdata == 32'd0))) errs++;
      tick();
    end
    check("clear_seq_errs", errs, 32'd0);
    check("clear_end_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < NBINS; i++) model_bins[i] = 32'd0;
  endtask

  initial begin
    ARESETN = 1'b0; cmd_start = 1'b0; cmd_clear = 1'b0;
    s_tvalid = 1'b0; s_tdata = 8'd0; s_tlast = 1'b0;
    hst_rd = 1'b0; hst_addr = 8'd0;
    pre_en = 1'b0; pre_addr = 8'd0; pre_data = 32'd0;
    rd_tab[0] = '{addr: 8'd3,   cnt: 32'd3};
    rd_tab[1] = '{addr: 8'd7,   cnt: 32'd1};
    rd_tab[2] = '{addr: 8'd5,   cnt: 32'd3};
    rd_tab[3] = '{addr: 8'd9,   cnt: 32'd1};
    rd_tab[4] = '{addr: 8'd0,   cnt: 32'd0};
    rd_tab[5] = '{addr: 8'd255, cnt: 32'd0};
    for (int i = 0; i < NBINS; i++) model_bins[i] = 32'd0;

    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pix_cnt", pix_cnt, 32'd0);
    check("rst_tready", {31'd0, s_tready}, 32'd0);
    check("rst_rvalid", {31'd0, hst_rvalid}, 32'd0);
    check("rst_rdata", hst_rdata, 32'd0);
    check("rst_we", {31'd0, ram_we}, 32'd0);
    check("rst_waddr", {24'd0, ram_waddr}, 32'd0);
    check("rst_wdata", ram_wdata, 32'd0);
    ARESETN = 1'b1;
    tick();

    // Clear all bins, then spot-read
    cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
    clear_body();
    read_check("clr_bin0", 8'd0, 32'd0);
    read_check("clr_bin128", 8'd128, 32'd0);
    tick();
    check("rdata_hold_rvalid", {31'd0, hst_rvalid}, 32'd0);
    read_check("clr_bin255", 8'd255, 32'd0);

    // Back-to-back same bin (forwarding)
    start_run();
    beat(1'b1, 8'd3, 1'b0); beat(1'b1, 8'd3, 1'b0); beat(1'b1, 8'd3, 1'b0); beat(1'b1, 8'd7, 1'b1);
    wait_done();
    check("pix_cnt_4", pix_cnt, 32'd4);

    // Same bin with a bubble in between
    start_run();
    beat(1'b1, 8'd5, 1'b0); beat(1'b0, 8'd5, 1'b0); beat(1'b1, 8'd5, 1'b0);
    beat(1'b1, 8'd9, 1'b0); beat(1'b1, 8'd5, 1'b1);
    wait_done();
    for (int i = 0; i < 6; i++) read_check("tab_bin", rd_tab[i].addr, rd_tab[i].cnt);

    // Commands and host reads during RUN are ignored
    start_run();
    beat(1'b1, 8'd4, 1'b0);
    cmd_start = 1'b1; beat(1'b1, 8'd4, 1'b0); cmd_start = 1'b0;
    check("start_in_run_pixcnt", pix_cnt, 32'd2);
    hst_rd = 1'b1; hst_addr = 8'd4; beat(1'b0, 8'd0, 1'b0); hst_rd = 1'b0;
    check("hst_rd_in_run", {31'd0, hst_rvalid}, 32'd0);
    cmd_clear = 1'b1; beat(1'b0, 8'd0, 1'b0); cmd_clear = 1'b0;
    check("clear_in_run_tready", {31'd0, s_tready}, 32'd1);
    beat(1'b1, 8'd4, 1'b1);
    wait_done();
    read_check("bin4", 8'd4, 32'd3);

    // Saturation
    pre_en = 1'b1; pre_addr = 8'd2; pre_data = 32'hFFFF_FFFE; tick(); pre_en = 1'b0;
    model_bins[2] = 32'hFFFF_FFFE;
    start_run();
    beat(1'b1, 8'd2, 1'b0); beat(1'b1, 8'd2, 1'b0); beat(1'b1, 8'd2, 1'b1);
    wait_done();
    read_check("bin2_sat", 8'd2, 32'hFFFF_FFFF);

    // Start + clear + host read together from DONE: clear wins, others dropped
    cmd_start = 1'b1; cmd_clear = 1'b1; hst_rd = 1'b1; hst_addr = 8'd3;
    tick();
    cmd_start = 1'b0; cmd_clear = 1'b0; hst_rd = 1'b0;
    check("both_cmd_busy", {31'd0, busy}, 32'd1);
    check("both_cmd_tready", {31'd0, s_tready}, 32'd0);
    check("both_cmd_rvalid", {31'd0, hst_rvalid}, 32'd0);
    clear_body();

    // Randomized stream over 16 bins against the reference model
    start_run();
    for (int i = 0; i < 300; i++) begin
      logic v;
      v = (i == 299) ? 1'b1 : ($urandom_range(0, 3) != 0);
      beat(v, 8'($urandom_range(0, 15)), (i == 299) ? 1'b1 : 1'b0);
    end
    wait_done();
    for (int b = 0; b < 16; b++) read_check("rand_bin", b[PIX_W-1:0], model_bins[b]);

    // Asynchronous reset in the middle of RUN
    start_run();
    for (int i = 0; i < 10; i++) beat(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    s_tvalid = 1'b1; s_tdata = 8'd17;
    #1 ARESETN = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_pix_cnt", pix_cnt, 32'd0);
    check("mid_rst_tready", {31'd0, s_tready}, 32'd0);
    check("mid_rst_we", {31'd0, ram_we}, 32'd0);
    check("mid_rst_raddr", {24'd0, ram_raddr}, 32'd0);
    check("mid_rst_wdata", ram_wdata, 32'd0);
    begin
      int we_seen = 0;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (ram_we) we_seen++;
      end
      check("mid_rst_we_hold", we_seen, 32'd0);
    end
    ARESETN = 1'b1; s_tvalid = 1'b0;
    tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_tready", {31'd0, s_tready}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/histogram_bin_ctrl.md
Name: histogram_bin_ctrl

Overview:
Sequencer for the histogram bin memory behind the AXI4-Lite register slave.
- Takes start/clear commands from the register block.
- Accepts a pixel stream with a valid/ready handshake and performs a pipelined read-modify-write increment of the bin RAM, with same-bin hazard forwarding.
- Zeroes all bins on command.
- Serves host bin reads when idle.
- Drives an external simple-dual-port RAM: synchronous read, 1-cycle latency, read-first.

Parameters:
PIX_W, 8, pixel/bin-address width; NBINS = 2**PIX_W
CNT_W, 32, bin counter and pixel counter width

Ports:
ACLK  in  1  clock, all logic rising-edge
ARESETN  in  1  asynchronous active-low reset
cmd_start  in  1  1-cycle pulse, begin accumulation
cmd_clear  in  1  1-cycle pulse, zero all bins
busy  out  1  high in CLEAR, RUN, DRAIN
done  out  1  high in DONE
pix_cnt  out  CNT_W  pixels accepted since last start
s_tvalid  in  1  pixel valid
s_tready  out  1  pixel ready
s_tdata  in  PIX_W  pixel value = bin index
s_tlast  in  1  last pixel of frame
hst_rd  in  1  host read request pulse
hst_addr  in  PIX_W  host bin index
hst_rvalid  out  1  host read data valid
hst_rdata  out  CNT_W  host bin count
ram_raddr  out  PIX_W  RAM read address
ram_rdata  in  CNT_W  RAM read data, valid the cycle after ram_raddr
ram_we  out  1  RAM write enable
ram_waddr  out  PIX_W  RAM write address
ram_wdata  out  CNT_W  RAM write data

Behaviour:
- Reset values: state IDLE; busy=0, done=0, pix_cnt=0, s_tready=0, hst_rvalid=0, hst_rdata=0, ram_we=0, ram_raddr=0, ram_waddr=0, ram_wdata=0; pipeline valid bits cleared. RAM contents are undefined after reset; software must issue a clear.
- States and transitions:
  - IDLE and DONE: cmd_clear -> CLEAR; else cmd_start -> RUN. If both pulse together, clear wins and start is dropped.
  - CLEAR: bin index counter k runs 0..NBINS-1, one bin per cycle (ram_we=1, ram_waddr=k, ram_wdata=0). Takes exactly NBINS cycles, then -> IDLE.
  - RUN: s_tready=1. An accepted beat with s_tlast=1 -> DRAIN.
  - DRAIN: 1 cycle; the final write is issued; -> DONE.
- Commands while busy: cmd_start and cmd_clear are ignored.
- Pixel counter: pix_cnt is zeroed on the cycle RUN is entered. It increments on each accepted beat and wraps at 2**CNT_W.
- RMW pipeline:
  - Stage 0 (accept cycle t): ram_raddr = s_tdata; register a1 = s_tdata, v1 = 1.
  - Stage 1 (cycle t+1, v1=1): operand = fwd ? wdata_q : ram_rdata. Write ram_waddr = a1, ram_wdata = operand+1, ram_we = 1.
  - The sum saturates at all-ones and never wraps.
  - fwd = 1 when the previous cycle wrote (we_q=1) and waddr_q == a1. This covers back-to-back same-bin beats, because the read-first RAM returns stale data in that case.
  - Sustained throughput is 1 pixel/cycle. Bubbles (s_tvalid=0) insert no write.
- Host read:
  - Accepted only in IDLE or DONE. hst_rd drives ram_raddr = hst_addr.
  - On the next cycle: hst_rvalid=1 for 1 cycle, hst_rdata = ram_rdata, which is held until the next valid read.
  - A hst_rd in any other state is dropped and hst_rvalid stays 0.
  - A hst_rd coinciding with a cmd_start/cmd_clear that is accepted is dropped.
- Reset mid-operation: asynchronous return to IDLE. Any in-flight write is abandoned and no ram_we is asserted during or after reset.
- Bin read address mux: the RMW pipeline owns it in RUN and DRAIN; the host owns it in IDLE and DONE.

Test Plan:
- Reset, cmd_clear -> busy high for exactly 256 cycles with ram_we=1 and waddr 0..255, wdata=0; then IDLE; host read of bins 0, 128 and 255 each returns 0.
- Clear, then start; stream 3,3,3,7 with s_tvalid held high and tlast on 7 -> bin3=3 (forwarding exercised), bin7=1, pix_cnt=4, done=1.
- Stream 5,bubble,5,9,5 back-to-back/with gap, tlast on last -> bin5=3, bin9=1; no lost increments.
- Preload bin 2 = 0xFFFFFFFE via the RAM model, stream 2,2,2 -> bin2=0xFFFFFFFF (saturated).
- cmd_start and cmd_clear in the same cycle from DONE -> CLEAR entered, start ignored; cmd_start during RUN -> no effect; hst_rd during RUN -> hst_rvalid stays 0.
- Deassert ARESETN mid-RUN after 10 beats -> all outputs at reset values immediately; ram_we=0 throughout reset.
